tsall_ctrl: RTL and testbench
=============================

# tsall_ctrl

Sequencer for the device-wide global output-tristate input (`TSALLN`, active low). It holds all user outputs tristated through reset and a programmable release delay. It then arbitrates tristate requests from up to `NREQ` sources such as debug, test and power management. Each request episode asserts `TSALLN` for a guaranteed minimum hold time. The block sits at the top level, directly driving the `TSALLN` pin of the global-tristate primitive.

## Interface
- `NREQ`, 4: number of tristate requesters, ≥1.
- `REL_DLY`, 16: cycles `TSALLN` stays low after reset deassertion, ≥1.
- `MIN_HOLD`, 8: minimum cycles `TSALLN` stays low per request episode, ≥1.
- `CNT_W`, 8: counter width; must hold max(`REL_DLY`,`MIN_HOLD`)−1.

Ports:
- `CLK` in 1: sole clock, rising edge.
- `RSTN` in 1: reset, asynchronous assert, active-low (already decided).
- `REQ` in `NREQ`: level tristate requests, synchronous to `CLK`.
- `TSALLN` out 1: registered global tristate control; 0 = outputs tristated.
- `ACK` out `NREQ`: per-requester grant; tristate is in effect while its `REQ` is held.
- `OWNER` out max(1,$clog2(`NREQ`)): index of the requester that caused the last entry.
- `ENTRIES` out 8: saturating count of RUN→TRI entries.

## Operation
- States:
  - INIT: after reset.
  - RUN: outputs enabled.
  - TRI: outputs tristated by request.
- Reset (`RSTN`=0, asynchronous):
  - State = INIT, counter = `REL_DLY`−1.
  - `TSALLN`=0, `ACK`=0, `OWNER`=0, `ENTRIES`=0, all immediately.
- INIT:
  - Counter decrements each edge.
  - At an edge with counter==0: if `REQ`==0 go to RUN, else go to TRI with counter = `MIN_HOLD`−1.
  - INIT→TRI does not increment `ENTRIES` and does not update `OWNER`.
- RUN:
  - At an edge with `REQ`≠0: go to TRI, counter = `MIN_HOLD`−1.
  - `OWNER` = lowest set index of `REQ`.
  - `ENTRIES` += 1, saturating at 255.
- TRI:
  - Counter decrements to 0 and holds there.
  - At an edge with counter==0 and `REQ`==0: go to RUN.
  - Otherwise stay in TRI. Requests arriving or leaving while in TRI never reload the counter.
- Outputs are registered from the next state:
  - `TSALLN` = (next==RUN).
  - `ACK` = `REQ` & (next==TRI), i.e. `ACK` is 0 in INIT and RUN.
- Reset mid-operation: all state is discarded and the full `REL_DLY` sequence restarts. No glitch high on `TSALLN` during reset.

## Timing
- Reset release: `TSALLN` rises after the `REL_DLY`-th rising edge following `RSTN` deassertion, provided `REQ`==0.
- Entry latency: `REQ` sampled at edge k in RUN gives `TSALLN`=0 and the matching `ACK` bits =1 after edge k.
- Minimum hold: `TSALLN` low for ≥`MIN_HOLD` cycles per entry.
  - Exactly `MIN_HOLD` cycles when `REQ` drops within the hold.
  - Otherwise low until the edge after the last `REQ` drops.
- `ACK` tracks `REQ` with one-cycle latency while in TRI.
- `REQ` rising at the same edge the counter reaches 0: block stays in TRI, no new entry is counted.

## Structure
- Shared package `tsall_pkg` holds:
  - the state enum (INIT/RUN/TRI);
  - the `ENTRIES` width and saturation constant (8, 255);
  - the owner-width function max(1,$clog2(n)).
- One sub-module, `tsall_prio_enc`: parameterized lowest-index priority encoder for `OWNER`.
- The FSM, counter and status registers live in `tsall_ctrl`.

## Test plan
Defaults: `NREQ`=4, `REL_DLY`=16, `MIN_HOLD`=8.

- Release `RSTN` with `REQ`=0 → `TSALLN`=0 through 15 edges, =1 after edge 16; `ACK`=0, `ENTRIES`=0, `OWNER`=0.
- In RUN, pulse `REQ`=4'b0100 for one cycle → `TSALLN` low exactly 8 cycles, `ACK`=4'b0100 for 1 cycle, `OWNER`=2, `ENTRIES`=1.
- In RUN, `REQ`=4'b1010; drop bit1 after 3 cycles, hold bit3 for 20 cycles → `OWNER`=1; `ACK`=4'b1010 then 4'b1000; `TSALLN` returns high one edge after bit3 drops.
- Drive 300 separate entries → `ENTRIES` saturates at 255 and stays there.
- Assert `RSTN` mid-TRI with `REQ`=4'b0001 held through release → immediate `TSALLN`=0 and `ACK`=0. After 16 edges, INIT→TRI with `ACK`=4'b0001; `ENTRIES`=0, `OWNER`=0.
- In TRI, raise `REQ` bit0 exactly at the edge the counter reaches 0 → `TSALLN` stays low with no high glitch, `ENTRIES` unchanged.

Source files
------------

// File: rtl/tsall_pkg.sv
// Shared types and constants for the global output-tristate sequencer.
package tsall_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRI  = 2'd2
  } state_e;

  localparam int                   ENTRIES_W   = 8;
  localparam logic [ENTRIES_W-1:0] ENTRIES_MAX = 8'd255;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int owner_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tsall_prio_enc.sv
// Lowest-index-wins priority encoder; returns 0 when no bit is set.
module tsall_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/tsall_ctrl.sv
// Global tristate (TSALLN) sequencer: reset release delay, request arbitration
// and a guaranteed minimum tristate hold per request episode.
//
// state | meaning
// INIT  | after reset, outputs tristated while the release delay counts down
// RUN   | outputs enabled, waiting for any request
// TRI   | outputs tristated by request, minimum hold then wait for all to drop
module tsall_ctrl
  import tsall_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int REL_DLY  = 16,
  parameter int MIN_HOLD = 8,
  parameter int CNT_W    = 8,
  localparam int OWN_W   = owner_w(NREQ)
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic [NREQ-1:0]      REQ,
  output logic                 TSALLN,
  output logic [NREQ-1:0]      ACK,
  output logic [OWN_W-1:0]     OWNER,
  output logic [ENTRIES_W-1:0] ENTRIES
);

  localparam logic [CNT_W-1:0] REL_LD  = CNT_W'(REL_DLY - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(MIN_HOLD - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   tsalln_q, tsalln_d;
  logic [NREQ-1:0]        ack_q, ack_d;
  logic [OWN_W-1:0]       owner_q, owner_d;
  logic [ENTRIES_W-1:0]   entries_q, entries_d;
  logic [OWN_W-1:0]       enc_idx;
  logic                   cnt_zero;
  logic                   req_any;

  tsall_prio_enc #(
    .N (NREQ),
    .W (OWN_W)
  ) u_prio_enc (
    .req (REQ),
    .idx (enc_idx)
  );

  assign cnt_zero = (cnt_q == '0);
  assign req_any  = |REQ;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    entries_d = entries_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_zero) begin
          if (req_any) begin
            state_d = ST_TRI;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (req_any) begin
          state_d = ST_TRI;
          cnt_d   = HOLD_LD;
          owner_d = enc_idx;
          if (entries_q != ENTRIES_MAX) entries_d = entries_q + ENTRIES_W'(1);
        end
      end
      ST_TRI: begin
        // Requests changing inside TRI never reload the hold counter.
        if (cnt_zero) begin
          if (!req_any) state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = REL_LD;
      end
    endcase
    tsalln_d = (state_d == ST_RUN);
    ack_d    = REQ & {NREQ{state_d == ST_TRI}};
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= ST_INIT;
      cnt_q     <= REL_LD;
      tsalln_q  <= 1'b0;
      ack_q     <= '0;
      owner_q   <= '0;
      entries_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tsalln_q  <= tsalln_d;
      ack_q     <= ack_d;
      owner_q   <= owner_d;
      entries_q <= entries_d;
    end
  end

  assign TSALLN  = tsalln_q;
  assign ACK     = ack_q;
  assign OWNER   = owner_q;
  assign ENTRIES = entries_q;

endmodule

// File: tb/tb_tsall_ctrl.sv
// Directed testbench for tsall_ctrl with default parameters (4 requesters,
// 16-cycle release delay, 8-cycle minimum hold).
module tb_tsall_ctrl;

  logic       CLK;
  logic       RSTN;
  logic [3:0] REQ;
  logic       TSALLN;
  logic [3:0] ACK;
  logic [1:0] OWNER;
  logic [7:0] ENTRIES;

  int checks = 0;
  int errors = 0;

  tsall_ctrl #(
    .NREQ     (4),
    .REL_DLY  (16),
    .MIN_HOLD (8),
    .CNT_W    (8)
  ) dut (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .REQ     (REQ),
    .TSALLN  (TSALLN),
    .ACK     (ACK),
    .OWNER   (OWNER),
    .ENTRIES (ENTRIES)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    REQ  = 4'b0000;
    #23;
    checks++; if (TSALLN !== 1'b0) begin errors++; $display("FAIL rst_tsalln got %b want 0", TSALLN); end
    checks++; if (ACK !== 4'b0000) begin errors++; $display("FAIL rst_ack got %b want 0000", ACK); end
    checks++; if (OWNER !== 2'd0) begin errors++; $display("FAIL rst_owner got %0d want 0", OWNER); end
    checks++; if (ENTRIES !== 8'd0) begin errors++; $display("FAIL rst_entries got %0d want 0", ENTRIES); end
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++; if (TSALLN !== 1'b0) begin errors++; $display("FAIL rel_low edge %0d got %b want 0", i, TSALLN); end
    end
    tick();
    checks++; if (TSALLN !== 1'b1) begin errors++; $display("FAIL rel_high edge16 got %b want 1", TSALLN); end
    checks++; if (ACK !== 4'b0000) begin errors++; $display("FAIL rel_ack got %b want 0000", ACK); end
    checks++; if (ENTRIES !== 8'd0) begin errors++; $display("FAIL rel_entries got %0d want 0", ENTRIES); end
    checks++; if (OWNER !== 2'd0) begin errors++; $display("FAIL rel_owner got %0d want 0", OWNER); end
  endtask

  task automatic test_pulse();
    REQ = 4'b0100;
    tick();
    REQ = 4'b0000;
    checks++; if (TSALLN !== 1'b0) begin errors++; $display("FAIL pulse_entry_tsalln got %b want 0", TSALLN); end
    checks++; if (ACK !== 4'b0100) begin errors++; $display("FAIL pulse_ack got %b want 0100", ACK); end
    checks++; if (OWNER !== 2'd2) begin errors++; $display("FAIL pulse_owner got %0d want 2", OWNER); end
    checks++; if (ENTRIES !== 8'd1) begin errors++; $display("FAIL pulse_entries got %0d want 1", ENTRIES); end
    for (int i = 2; i <= 8; i++) begin
      tick();
      checks++; if (TSALLN !== 1'b0) begin errors++; $display("FAIL pulse_hold cycle %0d got %b want 0", i, TSALLN); end
      checks++; if (ACK !== 4'b0000) begin errors++; $display("FAIL pulse_ack_off cycle %0d got %b want 0000", i, ACK); end
    end
    tick();
    checks++; if (TSALLN !== 1'b1) begin errors++; $display("FAIL pulse_release got %b want 1", TSALLN); end
  endtask

  task automatic test_multi();
    logic [3:0] exp_ack;
    for (int c = 0; c < 20; c++) begin
      REQ = (c < 3) ? 4'b1010 : 4'b1000;
      exp_ack = REQ;
      tick();
      checks++; if (TSALLN !== 1'b0) begin errors++; $display("FAIL multi_low cycle %0d got %b want 0", c, TSALLN); end
      checks++; if (ACK !== exp_ack) begin errors++; $display("FAIL multi_ack cycle %0d got %b want %b", c, ACK, exp_ack); end
    end
    checks++; if (OWNER !== 2'd1) begin errors++; $display("FAIL multi_owner got %0d want 1", OWNER); end
    checks++; if (ENTRIES !== 8'd2) begin errors++; $display("FAIL multi_entries got %0d want 2", ENTRIES); end
    REQ = 4'b0000;
    tick();
    checks++; if (TSALLN !== 1'b1) begin errors++; $display("FAIL multi_release got %b want 1", TSALLN); end
    checks++; if (ACK !== 4'b0000) begin errors++; $display("FAIL multi_ack_release got %b want 0000", ACK); end
  endtask

  task automatic test_saturate();
    int exp_entries;
    exp_entries = 2;
    for (int n = 0; n < 300; n++) begin
      REQ = 4'b0001;
      tick();
      REQ = 4'b0000;
      exp_entries = (exp_entries >= 255) ? 255 : exp_entries + 1;
      checks++; if (ENTRIES !== 8'(exp_entries)) begin errors++; $display("FAIL sat_entries n=%0d got %0d want %0d", n, ENTRIES, exp_entries); end
      repeat (8) tick();
    end
    checks++; if (ENTRIES !== 8'd255) begin errors++; $display("FAIL sat_final got %0d want 255", ENTRIES); end
    checks++; if (TSALLN !== 1'b1) begin errors++; $display("FAIL sat_run got %b want 1", TSALLN); end
  endtask

  task automatic test_reset_mid();
    REQ = 4'b0100;
    tick();
    checks++; if (OWNER !== 2'd2) begin errors++; $display("FAIL mid_owner_pre got %0d want 2", OWNER); end
    REQ = 4'b0001;
    tick();
    checks++; if (ACK !== 4'b0001) begin errors++; $display("FAIL mid_ack_pre got %b want 0001", ACK); end
    #2;
    RSTN = 1'b0;
    #1;
    checks++; if (TSALLN !== 1'b0) begin errors++; $display("FAIL mid_rst_tsalln got %b want 0", TSALLN); end
    checks++; if (ACK !== 4'b0000) begin errors++; $display("FAIL mid_rst_ack got %b want 0000", ACK); end
    checks++; if (ENTRIES !== 8'd0) begin errors++; $display("FAIL mid_rst_entries got %0d want 0", ENTRIES); end
    checks++; if (OWNER !== 2'd0) begin errors++; $display("FAIL mid_rst_owner got %0d want 0", OWNER); end
    @(posedge CLK);
    #1;
    checks++; if (TSALLN !== 1'b0) begin errors++; $display("FAIL mid_rst_held got %b want 0", TSALLN); end
    RSTN = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++; if (TSALLN !== 1'b0 || ACK !== 4'b0000) begin
        errors++; $display("FAIL mid_init edge %0d got tsalln=%b ack=%b want 0/0000", i, TSALLN, ACK);
      end
    end
    tick();
    checks++; if (TSALLN !== 1'b0) begin errors++; $display("FAIL mid_tri_tsalln got %b want 0", TSALLN); end
    checks++; if (ACK !== 4'b0001) begin errors++; $display("FAIL mid_tri_ack got %b want 0001", ACK); end
    checks++; if (ENTRIES !== 8'd0) begin errors++; $display("FAIL mid_tri_entries got %0d want 0", ENTRIES); end
    checks++; if (OWNER !== 2'd0) begin errors++; $display("FAIL mid_tri_owner got %0d want 0", OWNER); end
    REQ = 4'b0000;
    for (int i = 2; i <= 8; i++) begin
      tick();
      checks++; if (TSALLN !== 1'b0) begin errors++; $display("FAIL mid_hold cycle %0d got %b want 0", i, TSALLN); end
    end
    tick();
    checks++; if (TSALLN !== 1'b1) begin errors++; $display("FAIL mid_release got %b want 1", TSALLN); end
  endtask

  task automatic test_edge_zero();
    REQ = 4'b0010;
    tick();
    REQ = 4'b0000;
    checks++; if (ENTRIES !== 8'd1) begin errors++; $display("FAIL ez_entries_entry got %0d want 1", ENTRIES); end
    checks++; if (OWNER !== 2'd1) begin errors++; $display("FAIL ez_owner got %0d want 1", OWNER); end
    repeat (7) begin
      tick();
      checks++; if (TSALLN !== 1'b0) begin errors++; $display("FAIL ez_hold got %b want 0", TSALLN); end
    end
    // Counter now at 0; a request sampled on this edge must keep TRI.
    REQ = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (TSALLN !== 1'b0) begin errors++; $display("FAIL ez_glitch cycle %0d got %b want 0", i, TSALLN); end
      checks++; if (ACK !== 4'b0001) begin errors++; $display("FAIL ez_ack cycle %0d got %b want 0001", i, ACK); end
    end
    checks++; if (ENTRIES !== 8'd1) begin errors++; $display("FAIL ez_entries_hold got %0d want 1", ENTRIES); end
    REQ = 4'b0000;
    tick();
    checks++; if (TSALLN !== 1'b1) begin errors++; $display("FAIL ez_release got %b want 1", TSALLN); end
    checks++; if (ENTRIES !== 8'd1) begin errors++; $display("FAIL ez_entries_final got %0d want 1", ENTRIES); end
  endtask

  initial begin
    RSTN = 1'b0;
    REQ  = 4'b0000;
    test_reset();
    test_pulse();
    test_multi();
    test_saturate();
    test_reset_mid();
    test_edge_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
